// File: rtl/axi_to_mem_pkg.sv
// rtl/axi_to_mem_pkg.sv - shared state, burst and response encodings for the AXI4-to-memory bridge
package axi_to_mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      WRITE  = 2'd2,
      SEND_B = 2'd3
   } state_e;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] RESP_OKAY   = 2'b00;

endpackage

// File: rtl/axi_to_mem_addr_gen.sv
// rtl/axi_to_mem_addr_gen.sv - combinational next-beat address for FIXED/INCR/WRAP bursts
module axi_to_mem_addr_gen
   import axi_to_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 64
) (
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [2:0]            size_i,
   input  logic [7:0]            len_i,
   input  logic [1:0]            burst_i,
   output logic [ADDR_WIDTH-1:0] next_o
);

   logic [ADDR_WIDTH-1:0] beat_bytes;
   logic [ADDR_WIDTH-1:0] wrap_mask;

   always_comb begin
      beat_bytes = ADDR_WIDTH'(1) << size_i;
      wrap_mask  = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);
      next_o     = addr_i;
      case (burst_i)
         BURST_FIXED: next_o = addr_i;
         BURST_WRAP:  next_o = (addr_i & ~wrap_mask) | ((addr_i + beat_bytes) & wrap_mask);
         // reserved encoding falls through to INCR; first beat may be unaligned
         default:     next_o = (addr_i & ~(beat_bytes - ADDR_WIDTH'(1))) + beat_bytes;
      endcase
   end

endmodule

// File: rtl/axi_to_mem.sv
// rtl/axi_to_mem.sv - AXI4 slave to single-port memory bridge; optional handshake trace under AXI_TO_MEM_TRACE_EN
module axi_to_mem
   import axi_to_mem_pkg::*;
#(
   parameter int AXI_ID_WIDTH   = 5,
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_USER_WIDTH = 1,
   localparam int STRB_WIDTH    = AXI_DATA_WIDTH / 8
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      aw_valid,
   input  logic [AXI_ID_WIDTH-1:0]   aw_id,
   input  logic [AXI_ADDR_WIDTH-1:0] aw_addr,
   input  logic [7:0]                aw_len,
   input  logic [2:0]                aw_size,
   input  logic [1:0]                aw_burst,
   input  logic                      aw_lock,
   input  logic [3:0]                aw_cache,
   input  logic [2:0]                aw_prot,
   input  logic [3:0]                aw_qos,
   input  logic [3:0]                aw_region,
   input  logic [5:0]                aw_atop,
   input  logic [AXI_USER_WIDTH-1:0] aw_user,
   output logic                      aw_ready,
   input  logic                      w_valid,
   input  logic [AXI_DATA_WIDTH-1:0] w_data,
   input  logic [STRB_WIDTH-1:0]     w_strb,
   input  logic                      w_last,
   input  logic [AXI_USER_WIDTH-1:0] w_user,
   output logic                      w_ready,
   output logic                      b_valid,
   output logic [AXI_ID_WIDTH-1:0]   b_id,
   output logic [1:0]                b_resp,
   output logic [AXI_USER_WIDTH-1:0] b_user,
   input  logic                      b_ready,
   input  logic                      ar_valid,
   input  logic [AXI_ID_WIDTH-1:0]   ar_id,
   input  logic [AXI_ADDR_WIDTH-1:0] ar_addr,
   input  logic [7:0]                ar_len,
   input  logic [2:0]                ar_size,
   input  logic [1:0]                ar_burst,
   input  logic                      ar_lock,
   input  logic [3:0]                ar_cache,
   input  logic [2:0]                ar_prot,
   input  logic [3:0]                ar_qos,
   input  logic [3:0]                ar_region,
   input  logic [AXI_USER_WIDTH-1:0] ar_user,
   output logic                      ar_ready,
   output logic                      r_valid,
   output logic [AXI_DATA_WIDTH-1:0] r_data,
   output logic [1:0]                r_resp,
   output logic [AXI_ID_WIDTH-1:0]   r_id,
   output logic                      r_last,
   output logic [AXI_USER_WIDTH-1:0] r_user,
   input  logic                      r_ready,
   output logic                      req_o,
   output logic                      we_o,
   output logic [AXI_ADDR_WIDTH-1:0] addr_o,
   output logic [STRB_WIDTH-1:0]     be_o,
   output logic [AXI_DATA_WIDTH-1:0] data_o,
   input  logic [AXI_DATA_WIDTH-1:0] data_i
);

   state_e                    state_q, state_d;
   logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
   logic [7:0]                len_q, len_d;
   logic [2:0]                size_q, size_d;
   logic [1:0]                burst_q, burst_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]                cnt_q, cnt_d;
   logic [AXI_ADDR_WIDTH-1:0] next_addr;

   logic unused_sideband;
   assign unused_sideband = ^{aw_lock, aw_cache, aw_prot, aw_qos, aw_region, aw_atop, aw_user,
                              w_user, ar_lock, ar_cache, ar_prot, ar_qos, ar_region, ar_user};

   axi_to_mem_addr_gen #(
      .ADDR_WIDTH (AXI_ADDR_WIDTH)
   ) u_addr_gen (
      .addr_i  (addr_q),
      .size_i  (size_q),
      .len_i   (len_q),
      .burst_i (burst_q),
      .next_o  (next_addr)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         id_q    <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
         addr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         len_q   <= len_d;
         size_q  <= size_d;
         burst_q <= burst_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      id_d     = id_q;
      len_d    = len_q;
      size_d   = size_q;
      burst_d  = burst_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      ar_ready = 1'b0;
      aw_ready = 1'b0;
      w_ready  = 1'b0;
      b_valid  = 1'b0;
      b_id     = '0;
      b_resp   = RESP_OKAY;
      b_user   = '0;
      r_valid  = 1'b0;
      r_data   = '0;
      r_resp   = RESP_OKAY;
      r_id     = '0;
      r_last   = 1'b0;
      r_user   = '0;
      req_o    = 1'b0;
      we_o     = 1'b0;
      addr_o   = '0;
      be_o     = '0;
      data_o   = '0;

      case (state_q)
         IDLE: begin
            ar_ready = 1'b1;
            aw_ready = !ar_valid;
            if (ar_valid) begin
               id_d    = ar_id;
               len_d   = ar_len;
               size_d  = ar_size;
               burst_d = ar_burst;
               addr_d  = ar_addr;
               cnt_d   = '0;
               req_o   = 1'b1;
               addr_o  = ar_addr;
               be_o    = '1;
               state_d = READ;
            end else if (aw_valid) begin
               id_d    = aw_id;
               len_d   = aw_len;
               size_d  = aw_size;
               burst_d = aw_burst;
               addr_d  = aw_addr;
               state_d = WRITE;
            end
         end
         READ: begin
            r_valid = 1'b1;
            r_data  = data_i;
            r_id    = id_q;
            r_last  = (cnt_q == len_q);
            // next beat is requested on the accepting edge so data_i is ready one cycle later
            if (r_ready) begin
               if (r_last) begin
                  state_d = IDLE;
               end else begin
                  cnt_d  = cnt_q + 8'd1;
                  addr_d = next_addr;
                  req_o  = 1'b1;
                  addr_o = next_addr;
                  be_o   = '1;
               end
            end
         end
         WRITE: begin
            w_ready = 1'b1;
            if (w_valid) begin
               req_o  = 1'b1;
               we_o   = 1'b1;
               addr_o = addr_q;
               be_o   = w_strb;
               data_o = w_data;
               addr_d = next_addr;
               if (w_last) state_d = SEND_B;
            end
         end
         SEND_B: begin
            b_valid = 1'b1;
            b_id    = id_q;
            if (b_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef AXI_TO_MEM_TRACE_EN
   always @(negedge clk_i) begin
      if (ar_valid && ar_ready)
         $display("axi_to_mem AR addr=%h len=%0d size=%0d id=%h", ar_addr, ar_len, ar_size, ar_id);
      if (aw_valid && aw_ready)
         $display("axi_to_mem AW addr=%h len=%0d size=%0d id=%h", aw_addr, aw_len, aw_size, aw_id);
      if (w_valid && w_ready)
         $display("axi_to_mem W data=%h strb=%h last=%b", w_data, w_strb, w_last);
      if (r_valid && r_ready)
         $display("axi_to_mem R data=%h resp=%0d last=%b", r_data, r_resp, r_last);
      if (b_valid && b_ready)
         $display("axi_to_mem B id=%h resp=%0d", b_id, b_resp);
   end
`endif

endmodule

// File: tb/tb_axi_to_mem.sv
// tb/tb_axi_to_mem.sv - scoreboard bench for the AXI4-to-memory bridge
module tb_axi_to_mem;
   localparam int IW = 5;
   localparam int AW = 64;
   localparam int DW = 64;
   localparam int UW = 1;
   localparam int SW = DW / 8;

   logic clk_i = 1'b0;
   logic rst_i;
   always #5 clk_i = ~clk_i;

   logic          aw_valid, aw_ready, aw_lock;
   logic [IW-1:0] aw_id;
   logic [AW-1:0] aw_addr;
   logic [7:0]    aw_len;
   logic [2:0]    aw_size, aw_prot;
   logic [1:0]    aw_burst;
   logic [3:0]    aw_cache, aw_qos, aw_region;
   logic [5:0]    aw_atop;
   logic [UW-1:0] aw_user;
   logic          w_valid, w_ready, w_last;
   logic [DW-1:0] w_data;
   logic [SW-1:0] w_strb;
   logic [UW-1:0] w_user;
   logic          b_valid, b_ready;
   logic [IW-1:0] b_id;
   logic [1:0]    b_resp;
   logic [UW-1:0] b_user;
   logic          ar_valid, ar_ready, ar_lock;
   logic [IW-1:0] ar_id;
   logic [AW-1:0] ar_addr;
   logic [7:0]    ar_len;
   logic [2:0]    ar_size, ar_prot;
   logic [1:0]    ar_burst;
   logic [3:0]    ar_cache, ar_qos, ar_region;
   logic [UW-1:0] ar_user;
   logic          r_valid, r_ready, r_last;
   logic [DW-1:0] r_data;
   logic [1:0]    r_resp;
   logic [IW-1:0] r_id;
   logic [UW-1:0] r_user;
   logic          req_o, we_o;
   logic [AW-1:0] addr_o;
   logic [SW-1:0] be_o;
   logic [DW-1:0] data_o, data_i;

   axi_to_mem #(
      .AXI_ID_WIDTH(IW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_USER_WIDTH(UW)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .aw_valid(aw_valid), .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
      .aw_burst(aw_burst), .aw_lock(aw_lock), .aw_cache(aw_cache), .aw_prot(aw_prot), .aw_qos(aw_qos),
      .aw_region(aw_region), .aw_atop(aw_atop), .aw_user(aw_user), .aw_ready(aw_ready),
      .w_valid(w_valid), .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_user(w_user), .w_ready(w_ready),
      .b_valid(b_valid), .b_id(b_id), .b_resp(b_resp), .b_user(b_user), .b_ready(b_ready),
      .ar_valid(ar_valid), .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
      .ar_burst(ar_burst), .ar_lock(ar_lock), .ar_cache(ar_cache), .ar_prot(ar_prot), .ar_qos(ar_qos),
      .ar_region(ar_region), .ar_user(ar_user), .ar_ready(ar_ready),
      .r_valid(r_valid), .r_data(r_data), .r_resp(r_resp), .r_id(r_id), .r_last(r_last), .r_user(r_user),
      .r_ready(r_ready),
      .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .be_o(be_o), .data_o(data_o), .data_i(data_i)
   );

   typedef struct { logic we; logic [AW-1:0] addr; logic [SW-1:0] be; logic [DW-1:0] data; } req_t;
   typedef struct { logic [DW-1:0] data; logic last; logic [IW-1:0] id; } rbeat_t;

   req_t          exp_req[$];
   rbeat_t        exp_r[$];
   logic [IW-1:0] exp_b[$];
   req_t          mon_e;
   rbeat_t        mon_r;
   logic [IW-1:0] mon_b;
   int            passed = 0;
   int            total = 0;
   int            waits, cyc;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
      return {~a[31:0], a[31:0]};
   endfunction

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a, input logic [2:0] size,
                                         input logic [7:0] len, input logic [1:0] burst);
      logic [AW-1:0] s, m;
      s = 64'd1 << size;
      m = ((64'(len) + 64'd1) << size) - 64'd1;
      if (burst == 2'b00) return a;
      if (burst == 2'b10) return (a & ~m) | ((a + s) & m);
      return (a & ~(s - 64'd1)) + s;
   endfunction

   // memory with one-cycle read latency; data held until the next read request
   always @(posedge clk_i) if (req_o && !we_o) data_i <= mem_val(addr_o);

   always @(negedge clk_i) begin
      if (req_o) begin
         if (exp_req.size() == 0) chk("req_unexpected", addr_o, '1);
         else begin
            mon_e = exp_req.pop_front();
            chk("req_we", we_o, mon_e.we);
            chk("req_addr", addr_o, mon_e.addr);
            chk("req_be", be_o, mon_e.be);
            chk("req_data", data_o, mon_e.data);
         end
      end
      if (r_valid && r_ready) begin
         if (exp_r.size() == 0) chk("r_unexpected", r_data, '1);
         else begin
            mon_r = exp_r.pop_front();
            chk("r_data", r_data, mon_r.data);
            chk("r_last", r_last, mon_r.last);
            chk("r_id", r_id, mon_r.id);
            chk("r_resp", r_resp, 2'b00);
         end
      end
      if (b_valid && b_ready) begin
         if (exp_b.size() == 0) chk("b_unexpected", b_id, '1);
         else begin
            mon_b = exp_b.pop_front();
            chk("b_id", b_id, mon_b);
            chk("b_resp", b_resp, 2'b00);
         end
      end
   end

   task automatic expect_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
      logic [AW-1:0] a;
      a = addr;
      for (int i = 0; i <= int'(len); i++) begin
         exp_req.push_back('{1'b0, a, '1, '0});
         exp_r.push_back('{mem_val(a), (i == int'(len)), id});
         a = nxt(a, size, len, burst);
      end
   endtask

   task automatic ar_send(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, output int n);
      ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_valid = 1'b1;
      n = 0;
      @(negedge clk_i);
      while (!ar_ready && n < 20) begin n++; @(negedge clk_i); end
      if (n >= 20) chk("ar_timeout", n, 0);
      @(posedge clk_i); #1 ar_valid = 1'b0;
   endtask

   task automatic aw_send(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, output int n);
      aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_valid = 1'b1;
      n = 0;
      @(negedge clk_i);
      while (!aw_ready && n < 20) begin n++; @(negedge clk_i); end
      if (n >= 20) chk("aw_timeout", n, 0);
      @(posedge clk_i); #1 aw_valid = 1'b0;
   endtask

   task automatic w_send(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l, output int n);
      w_data = d; w_strb = s; w_last = l; w_valid = 1'b1;
      n = 0;
      @(negedge clk_i);
      while (!w_ready && n < 20) begin n++; @(negedge clk_i); end
      if (n >= 20) chk("w_timeout", n, 0);
      @(posedge clk_i); #1 w_valid = 1'b0;
   endtask

   task automatic drain(input string tag, output int c);
      c = 0;
      while ((exp_req.size() + exp_r.size() + exp_b.size()) != 0 && c < 50) begin
         @(posedge clk_i); c++;
      end
      chk({tag, "_drain"}, exp_req.size() + exp_r.size() + exp_b.size(), 0);
      #1;
   endtask

   initial begin
      rst_i = 1'b1;
      {aw_valid, aw_lock, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_cache, aw_prot} = '0;
      {aw_qos, aw_region, aw_atop, aw_user, w_valid, w_data, w_strb, w_last, w_user} = '0;
      {ar_valid, ar_lock, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_cache, ar_prot} = '0;
      {ar_qos, ar_region, ar_user} = '0;
      data_i = '0; b_ready = 1'b1; r_ready = 1'b1;

      @(negedge clk_i);
      chk("rst_ctrl", {req_o, we_o, r_valid, b_valid, w_ready}, 5'b0);
      chk("rst_bus", {addr_o, be_o, data_o}, '0);
      chk("rst_ready", {ar_ready, aw_ready}, 2'b11);
      @(posedge clk_i); #1 rst_i = 1'b0;

      // INCR read, four beats back to back
      expect_read(5'h11, 64'h4000_0000, 8'd3, 3'd3, 2'b01);
      ar_send(5'h11, 64'h4000_0000, 8'd3, 3'd3, 2'b01, waits);
      drain("incr_rd", cyc);
      chk("incr_rd_cycles", cyc, 4);

      // WRAP read wraps to the container base
      expect_read(5'h02, 64'h4000_0018, 8'd3, 3'd3, 2'b10);
      ar_send(5'h02, 64'h4000_0018, 8'd3, 3'd3, 2'b10, waits);
      drain("wrap_rd", cyc);

      // FIXED read: r_valid one cycle after the AR handshake
      expect_read(5'h03, 64'h2000, 8'd1, 3'd3, 2'b00);
      ar_send(5'h03, 64'h2000, 8'd1, 3'd3, 2'b00, waits);
      @(negedge clk_i);
      chk("rd_latency", r_valid, 1'b1);
      drain("fixed_rd", cyc);

      // single-beat write, B the cycle after w_last
      exp_req.push_back('{1'b1, 64'h4000_0008, 8'h0F, 64'hDEAD_BEEF});
      exp_b.push_back(5'h0A);
      aw_send(5'h0A, 64'h4000_0008, 8'd0, 3'd3, 2'b01, waits);
      w_send(64'hDEAD_BEEF, 8'h0F, 1'b1, waits);
      chk("w_ready_latency", waits, 0);
      @(negedge clk_i);
      chk("b_next_cycle", {b_valid, b_id}, {1'b1, 5'h0A});
      drain("single_wr", cyc);

      // unaligned INCR write; w_last ends it despite aw_len=0
      exp_req.push_back('{1'b1, 64'h1002, 8'h0C, 64'h1});
      exp_req.push_back('{1'b1, 64'h1004, 8'h0F, 64'h2});
      exp_req.push_back('{1'b1, 64'h1008, 8'hF0, 64'h3});
      exp_b.push_back(5'h02);
      aw_send(5'h02, 64'h1002, 8'd0, 3'd2, 2'b01, waits);
      w_send(64'h1, 8'h0C, 1'b0, waits);
      w_send(64'h2, 8'h0F, 1'b0, waits);
      w_send(64'h3, 8'hF0, 1'b1, waits);
      drain("unaligned_wr", cyc);

      // AR and AW together: read wins, AW taken after the read
      expect_read(5'h03, 64'h3000, 8'd0, 3'd3, 2'b01);
      exp_req.push_back('{1'b1, 64'h5000, 8'hFF, 64'h55});
      exp_b.push_back(5'h07);
      ar_id = 5'h03; ar_addr = 64'h3000; ar_len = 8'd0; ar_size = 3'd3; ar_burst = 2'b01;
      aw_id = 5'h07; aw_addr = 64'h5000; aw_len = 8'd0; aw_size = 3'd3; aw_burst = 2'b01;
      ar_valid = 1'b1; aw_valid = 1'b1;
      @(negedge clk_i);
      chk("both_ready", {ar_ready, aw_ready}, 2'b10);
      @(posedge clk_i); #1 ar_valid = 1'b0;
      aw_send(5'h07, 64'h5000, 8'd0, 3'd3, 2'b01, waits);
      chk("aw_after_read", waits, 1);
      w_send(64'h55, 8'hFF, 1'b1, waits);
      drain("ar_aw_prio", cyc);

      // r_ready stall mid-burst
      expect_read(5'h09, 64'h100, 8'd3, 3'd3, 2'b01);
      ar_send(5'h09, 64'h100, 8'd3, 3'd3, 2'b01, waits);
      @(posedge clk_i); #1 r_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("stall_hold", {r_valid, r_last, req_o}, 3'b100);
         chk("stall_data", r_data, mem_val(64'h108));
      end
      @(posedge clk_i); #1 r_ready = 1'b1;
      drain("stall_rd", cyc);

      // asynchronous reset in the middle of a write burst
      exp_req.push_back('{1'b1, 64'h6000, 8'hFF, 64'h1111});
      aw_send(5'h04, 64'h6000, 8'd3, 3'd3, 2'b01, waits);
      w_send(64'h1111, 8'hFF, 1'b0, waits);
      w_data = 64'h2222; w_strb = 8'hFF; w_last = 1'b0; w_valid = 1'b1;
      #2 rst_i = 1'b1;
      #1;
      chk("async_rst_ctrl", {req_o, we_o, w_ready, b_valid, r_valid}, 5'b0);
      chk("async_rst_bus", {addr_o, be_o, data_o}, '0);
      chk("async_rst_ready", {ar_ready, aw_ready}, 2'b11);
      w_valid = 1'b0;
      @(posedge clk_i); #1 rst_i = 1'b0;
      expect_read(5'h01, 64'h7000, 8'd0, 3'd3, 2'b00);
      ar_send(5'h01, 64'h7000, 8'd0, 3'd3, 2'b00, waits);
      chk("post_rst_ar_wait", waits, 0);
      drain("post_rst_rd", cyc);

      repeat (2) @(posedge clk_i);
      chk("queues_empty", exp_req.size() + exp_r.size() + exp_b.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/axi_to_mem.md
# axi_to_mem

AXI4 slave-to-SRAM bridge. Converts AXI4 burst transactions into a single-port request stream (`req_o`/`we_o`/`addr_o`/`be_o`/`data_o`) for a memory or IO register block with fixed one-cycle read latency. Sits behind one crossbar master port and serves the GPIO/host-IO region of the SoC. Handles one transaction at a time; there is no outstanding-transaction queue.

## Interface
Parameters:
- AXI_ID_WIDTH, 5: ID width of AW/AR/B/R.
- AXI_ADDR_WIDTH, 64: address width.
- AXI_DATA_WIDTH, 64: data width. STRB = AXI_DATA_WIDTH/8.
- AXI_USER_WIDTH, 1: user width.

Ports (timing: one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- AW channel:
  - in: aw_valid, aw_id[ID], aw_addr[ADDR], aw_len[8], aw_size[3], aw_burst[2].
  - out: aw_ready.
  - aw_lock, aw_cache, aw_prot, aw_qos, aw_region, aw_atop and aw_user are accepted and ignored.
- W channel:
  - in: w_valid, w_data[DATA], w_strb[STRB], w_last, w_user.
  - out: w_ready.
- B channel:
  - out: b_valid, b_id[ID], b_resp[2], b_user[USER].
  - in: b_ready.
- AR channel:
  - in: ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst.
  - out: ar_ready.
  - The remaining AR fields are ignored.
- R channel:
  - out: r_valid, r_data[DATA], r_resp[2], r_id[ID], r_last, r_user[USER].
  - in: r_ready.
- req_o  out  1  memory request strobe.
- we_o  out  1  1 = write, 0 = read.
- addr_o  out  ADDR  byte address of the beat.
- be_o  out  STRB  byte enables (all ones for reads).
- data_o  out  DATA  write data.
- data_i  in  DATA  read data.
  - Valid the cycle after a read request.
  - Held by the memory until its next request.

## Operation
FSM states: IDLE, READ, WRITE, SEND_B.

IDLE:
- ar_ready = 1.
- aw_ready = !ar_valid. AR has priority when AR and AW are both valid.
- On AR handshake:
  - Latch id, len, size, burst and address.
  - Issue req_o=1, we_o=0, addr_o=ar_addr in the same cycle.
  - Beat counter = 0. Go to READ.
- On AW handshake:
  - Latch the same fields.
  - Go to WRITE.

READ:
- r_valid=1, r_data=data_i, r_id=latched id, r_resp=OKAY (2'b00), r_user=0.
- r_last = 1 when the beat counter equals len.
- On r_valid&&r_ready:
  - If not last: increment the counter and issue req_o for the next beat address in the same cycle.
  - If last: go to IDLE.

WRITE:
- w_ready=1.
- On w_valid:
  - req_o=1, we_o=1, addr_o=current beat address, data_o=w_data, be_o=w_strb.
  - Advance the address.
  - If w_last: go to SEND_B.

SEND_B:
- b_valid=1, b_id=latched id, b_resp=OKAY, b_user=0.
- On b_ready: go to IDLE.

Address generation (beat size S = 1<<size):
- FIXED (0): address constant.
- INCR (1): next = (addr & ~(S-1)) + S. Beat 0 may be unaligned; later beats are aligned.
- WRAP (2):
  - mask = (len+1)*S - 1.
  - next = (addr & ~mask) | ((addr+S) & mask).
- Reserved (3): treated as INCR.
- The 64-bit address wraps modulo 2^ADDR. No 4 KB boundary check.

Error and boundary handling:
- Never returns an error response.
- w_last is authoritative for write termination. len is ignored for writes.
- aw_ready and ar_ready are 0 outside IDLE.

## Timing
- Reset (async assert, sync release): state=IDLE.
  - b_valid, r_valid, w_ready, req_o, we_o = 0.
  - addr_o, be_o, data_o = 0.
  - Latched id/len/size/burst = 0.
  - ar_ready=1 and aw_ready=1 once in IDLE (combinational).
- Read latency:
  - AR handshake in cycle 0 → r_valid in cycle 1.
  - Sustained throughput is 1 beat per cycle with r_ready held high.
- Write:
  - AW handshake in cycle 0 → w_ready in cycle 1.
  - Each accepted W beat issues req_o in the same cycle.
  - b_valid is asserted in the cycle after the w_last beat.
- Back-to-back: a new AR/AW is accepted one cycle after returning to IDLE.
- Reset mid-burst aborts the transaction immediately and drops the remaining beats.

## Configuration
- AXI_TO_MEM_TRACE_EN defined: a simulation-only `$display` fires at negedge clk_i for every AR, AW, W, R and B handshake, printing address/len/size/id or data/strb/resp.
- Undefined: no trace code is compiled. Synthesizable logic is identical either way.

## Structure
- Package axi_to_mem_pkg holds:
  - state enum (IDLE, READ, WRITE, SEND_B);
  - burst constants BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10;
  - RESP_OKAY=2'b00.
- One sub-module, axi_to_mem_addr_gen: combinational next-beat address from (addr, size, len, burst).

## Test plan
- INCR read, addr=0x4000_0000, len=3, size=3, r_ready=1:
  - req_o addresses 0x4000_0000, 0x08, 0x10, 0x18 on consecutive cycles;
  - 4 R beats, r_last only on the 4th, r_id echoes ar_id.
- WRAP read, addr=0x...18, len=3, size=3: addresses 0x18, 0x00, 0x08, 0x10.
- Single write, aw_addr=0x4000_0008, w_strb=0x0F, w_data=0xDEADBEEF, w_last=1:
  - req_o=1, we_o=1, be_o=0x0F, addr_o=0x4000_0008;
  - b_valid the next cycle with OKAY and the AW id.
- AR and AW valid in the same cycle: read completes first, then AW is accepted.
- r_ready low for 3 cycles mid-burst: r_valid and r_data stay stable, and no new req_o is issued until r_ready is high.
- rst_i pulsed during WRITE: all outputs return to reset values asynchronously; the FSM restarts in IDLE.
